// File: rtl/ngalu_pkg.sv
// Shared types and constants for the pipelined ALU: opcode encodings,
// status-flag bit positions and the packed flag bundle.
package ngalu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_XOR = 3'b010,
        OP_NOT = 3'b011,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101,
        OP_INC = 3'b110,
        OP_DEC = 3'b111
    } opcode_t;

    // Bit positions of the status flags within the 4-bit flags word.
    localparam int FLG_Z = 3;
    localparam int FLG_N = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    // Field order matches the FLG_* positions: {Z,N,C,V}.
    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } ngalu_flags_t;

endpackage

// File: rtl/ngalu_pipe_if.sv
// Operation request / result bus of the pipelined ALU. The master side
// issues operations and consumes results; the slave side is the ALU.
interface ngalu_pipe_if
    import ngalu_pkg::*;
#(
    parameter int WIDTH = 16
);

    logic               in_valid;
    logic               in_ready;
    opcode_t            opcode;
    logic               zx;
    logic               sw;
    logic               use_acc;
    logic               acc_clr;
    logic [WIDTH-1:0]   reg1;
    logic [WIDTH-1:0]   reg2;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   result;
    ngalu_flags_t       flags;
    logic [WIDTH-1:0]   acc;

    modport master (
        output in_valid, opcode, zx, sw, use_acc, acc_clr, reg1, reg2, out_ready,
        input  in_ready, out_valid, result, flags, acc
    );

    modport slave (
        input  in_valid, opcode, zx, sw, use_acc, acc_clr, reg1, reg2, out_ready,
        output in_ready, out_valid, result, flags, acc
    );

endinterface

// File: rtl/ngalu_core.sv
// Combinational ALU core: computes the result and {Z,N,C,V} for one
// operation on already-selected x/y operands.
module ngalu_core
    import ngalu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  opcode_t          op,
    output logic [WIDTH-1:0] result,
    output ngalu_flags_t     flags
);

    logic               is_sub;
    logic [WIDTH-1:0]   b;
    logic [WIDTH:0]     ext;
    logic signed [WIDTH-1:0] xs;
    logic signed [WIDTH-1:0] bs;
    logic signed [WIDTH-1:0] rs;

    // Shared adder/subtractor: inc/dec reuse it with a constant 1 operand.
    // The extra MSB of ext is the carry for adds and the borrow for subtracts.
    always_comb begin
        is_sub = (op == OP_SUB) || (op == OP_DEC);
        b      = ((op == OP_ADD) || (op == OP_SUB)) ? y : {{(WIDTH-1){1'b0}}, 1'b1};
        ext    = is_sub ? ({1'b0, x} - {1'b0, b}) : ({1'b0, x} + {1'b0, b});
    end

    // Opcode decode, result select and flag generation.
    always_comb begin
        result = '0;
        flags  = '0;
        xs     = signed'(x);
        bs     = signed'(b);
        rs     = signed'(ext[WIDTH-1:0]);
        case (op)
            OP_AND:  result = x & y;
            OP_OR:   result = x | y;
            OP_XOR:  result = x ^ y;
            OP_NOT:  result = ~x;
            default: begin
                result  = ext[WIDTH-1:0];
                flags.c = ext[WIDTH];
                // Signed overflow: add overflows when operands share a sign the
                // result lacks; subtract when operands differ and the result
                // sign departs from the minuend.
                if (is_sub) begin
                    flags.v = ((xs < 0) != (bs < 0)) && ((rs < 0) != (xs < 0));
                end else begin
                    flags.v = ((xs < 0) == (bs < 0)) && ((rs < 0) != (xs < 0));
                end
            end
        endcase
        flags.z = (result == '0);
        flags.n = result[WIDTH-1];
    end

endmodule

// File: rtl/ngalu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes and an accumulator.
// S1 registers the request, the core computes between S1 and S2, S2 holds
// the result for the consumer. The accumulator is written on the S1->S2
// transfer, so each op sees the accumulator left by all earlier ops.
module ngalu_pipe
    import ngalu_pkg::*;
#(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] ACC_RST = '0
) (
    input  logic          clk,
    input  logic          rst,
    ngalu_pipe_if.slave   bus
);

    logic               vld_p1;
    opcode_t            op_p1;
    logic               zx_p1;
    logic               sw_p1;
    logic               use_acc_p1;
    logic               clr_p1;
    logic [WIDTH-1:0]   reg1_p1;
    logic [WIDTH-1:0]   reg2_p1;

    logic               vld_p2;
    logic [WIDTH-1:0]   result_p2;
    ngalu_flags_t       flags_p2;

    logic [WIDTH-1:0]   acc_q;
    logic               adv2;
    logic               in_ready;
    logic [WIDTH-1:0]   x;
    logic [WIDTH-1:0]   y;
    logic [WIDTH-1:0]   core_res;
    ngalu_flags_t       core_flg;

    // Handshake: S2 advances when empty or drained; S1 moves with S2, so a
    // full pipe still accepts one op per cycle while the consumer drains.
    always_comb begin
        adv2     = !vld_p2 || bus.out_ready;
        in_ready = !vld_p1 || adv2;
    end

    // Operand selection from the S1 request; zx only affects x.
    always_comb begin
        x = zx_p1 ? '0 : (sw_p1 ? reg2_p1 : reg1_p1);
        y = use_acc_p1 ? acc_q : (sw_p1 ? reg1_p1 : reg2_p1);
    end

    ngalu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .x      (x),
        .y      (y),
        .op     (op_p1),
        .result (core_res),
        .flags  (core_flg)
    );

    // ---- Stage 1: request capture ----
    // S1 valid: loads on any cycle S1 can take a new op.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (in_ready) begin
            vld_p1 <= bus.in_valid;
        end
    end

    // S1 data: captured only on an accepted op.
    always_ff @(posedge clk) begin
        if (in_ready && bus.in_valid) begin
            op_p1      <= bus.opcode;
            zx_p1      <= bus.zx;
            sw_p1      <= bus.sw;
            use_acc_p1 <= bus.use_acc;
            clr_p1     <= bus.acc_clr;
            reg1_p1    <= bus.reg1;
            reg2_p1    <= bus.reg2;
        end
    end

    // ---- Stage 2: result register ----
    // S2 holds result/flags stable under backpressure, loads on S1->S2 transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2    <= 1'b0;
            result_p2 <= '0;
            flags_p2  <= '0;
        end else if (adv2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                result_p2 <= core_res;
                flags_p2  <= core_flg;
            end
        end
    end

    // Accumulator: written exactly when an op leaves S1, never during reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= ACC_RST;
        end else if (vld_p1 && adv2) begin
            acc_q <= clr_p1 ? ACC_RST : core_res;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = vld_p2;
    assign bus.result    = result_p2;
    assign bus.flags     = flags_p2;
    assign bus.acc       = acc_q;

endmodule

// File: tb/tb_ngalu_pipe.sv
// Directed bench for ngalu_pipe at WIDTH=16 and WIDTH=8.
module tb_ngalu_pipe;
    import ngalu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    ngalu_pipe_if #(.WIDTH(16)) bus16 ();
    ngalu_pipe_if #(.WIDTH(8))  bus8  ();

    ngalu_pipe #(.WIDTH(16), .ACC_RST(16'h0000)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    ngalu_pipe #(.WIDTH(8), .ACC_RST(8'h00)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one op on the 16-bit bus from idle and wait for its result.
    task automatic send16(input opcode_t op, input logic zx, input logic sw,
                          input logic ua, input logic clr,
                          input logic [15:0] r1, input logic [15:0] r2,
                          output logic [15:0] res, output logic [3:0] flg,
                          output int lat);
        @(negedge clk);
        bus16.opcode = op; bus16.zx = zx; bus16.sw = sw;
        bus16.use_acc = ua; bus16.acc_clr = clr;
        bus16.reg1 = r1; bus16.reg2 = r2;
        bus16.out_ready = 1'b1; bus16.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus16.in_valid = 1'b0;
        lat = 1;
        while (!bus16.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        res = bus16.result;
        flg = bus16.flags;
    endtask

    task automatic send8(input opcode_t op, input logic [7:0] r1, input logic [7:0] r2,
                         output logic [7:0] res, output logic [3:0] flg, output int lat);
        @(negedge clk);
        bus8.opcode = op; bus8.zx = 1'b0; bus8.sw = 1'b0;
        bus8.use_acc = 1'b0; bus8.acc_clr = 1'b0;
        bus8.reg1 = r1; bus8.reg2 = r2;
        bus8.out_ready = 1'b1; bus8.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus8.in_valid = 1'b0;
        lat = 1;
        while (!bus8.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        res = bus8.result;
        flg = bus8.flags;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus16.in_valid = 1'b0; bus16.out_ready = 1'b0;
        bus8.in_valid = 1'b0;  bus8.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus16.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid16: got %b expected 0", bus16.out_valid); end
        checks++; if (bus16.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready16: got %b expected 1", bus16.in_ready); end
        checks++; if (bus16.result !== 16'h0000) begin errors++; $display("FAIL rst_result16: got %h expected 0000", bus16.result); end
        checks++; if (bus16.flags !== 4'b0000) begin errors++; $display("FAIL rst_flags16: got %b expected 0000", bus16.flags); end
        checks++; if (bus16.acc !== 16'h0000) begin errors++; $display("FAIL rst_acc16: got %h expected 0000", bus16.acc); end
        checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid8: got %b expected 0", bus8.out_valid); end
        checks++; if (bus8.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready8: got %b expected 1", bus8.in_ready); end
        checks++; if (bus8.acc !== 8'h00) begin errors++; $display("FAIL rst_acc8: got %h expected 00", bus8.acc); end
        rst = 1'b0;
    endtask

    task automatic test_add();
        logic [15:0] res; logic [3:0] flg; int lat;
        send16(OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0001, res, flg, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL add_latency: got %0d expected 2", lat); end
        checks++; if (res !== 16'h0000) begin errors++; $display("FAIL add_result: got %h expected 0000", res); end
        checks++; if (flg !== 4'b1010) begin errors++; $display("FAIL add_flags: got %b expected 1010", flg); end
    endtask

    task automatic test_sub();
        logic [15:0] res; logic [3:0] flg; int lat;
        send16(OP_SUB, 1'b0, 1'b0, 1'b0, 1'b0, 16'h8000, 16'h0001, res, flg, lat);
        checks++; if (res !== 16'h7FFF) begin errors++; $display("FAIL sub_ovf_result: got %h expected 7fff", res); end
        checks++; if (flg !== 4'b0001) begin errors++; $display("FAIL sub_ovf_flags: got %b expected 0001", flg); end
        send16(OP_SUB, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0003, 16'h0005, res, flg, lat);
        checks++; if (res !== 16'hFFFE) begin errors++; $display("FAIL sub_borrow_result: got %h expected fffe", res); end
        checks++; if (flg !== 4'b0110) begin errors++; $display("FAIL sub_borrow_flags: got %b expected 0110", flg); end
        send16(OP_DEC, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234, res, flg, lat);
        checks++; if (res !== 16'hFFFF || flg !== 4'b0110) begin errors++; $display("FAIL dec_zero: got %h/%b expected ffff/0110", res, flg); end
        send16(OP_INC, 1'b0, 1'b0, 1'b0, 1'b0, 16'h7FFF, 16'h0000, res, flg, lat);
        checks++; if (res !== 16'h8000 || flg !== 4'b0101) begin errors++; $display("FAIL inc_ovf: got %h/%b expected 8000/0101", res, flg); end
        send16(OP_XOR, 1'b0, 1'b0, 1'b0, 1'b0, 16'hF0F0, 16'hFF00, res, flg, lat);
        checks++; if (res !== 16'h0FF0 || flg !== 4'b0000) begin errors++; $display("FAIL xor: got %h/%b expected 0ff0/0000", res, flg); end
    endtask

    task automatic test_zx_sw();
        logic [15:0] res; logic [3:0] flg; int lat;
        send16(OP_NOT, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h5678, res, flg, lat);
        checks++; if (res !== 16'hFFFF) begin errors++; $display("FAIL zx_not_result: got %h expected ffff", res); end
        checks++; if (flg !== 4'b0100) begin errors++; $display("FAIL zx_not_flags: got %b expected 0100", flg); end
        send16(OP_SUB, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0005, 16'h0009, res, flg, lat);
        checks++; if (res !== 16'h0004) begin errors++; $display("FAIL sw_sub_result: got %h expected 0004", res); end
        checks++; if (flg !== 4'b0000) begin errors++; $display("FAIL sw_sub_flags: got %b expected 0000", flg); end
        send16(OP_AND, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, res, flg, lat);
        checks++; if (res !== 16'h0000 || flg !== 4'b1000) begin errors++; $display("FAIL zx_and: got %h/%b expected 0000/1000", res, flg); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] got[$];
        logic [15:0] exp_r [3] = '{16'h0005, 16'h0007, 16'h0008};
        logic        clr_v [3] = '{1'b1, 1'b0, 1'b0};
        logic        ua_v  [3] = '{1'b0, 1'b1, 1'b1};
        logic [15:0] r1_v  [3] = '{16'h0002, 16'h0007, 16'h0001};
        logic [15:0] r2_v  [3] = '{16'h0003, 16'h0000, 16'h0000};
        int  drv = 0;
        bit  gap = 1'b0;
        bit  acc_bad = 1'b0;
        bus16.out_ready = 1'b1;
        for (int c = 0; c < 12 && got.size() < 3; c++) begin
            @(negedge clk);
            if (bus16.out_valid) got.push_back(bus16.result);
            // After the first op leaves S1, the clear must already be visible.
            if (c == 2 && bus16.acc !== 16'h0000) acc_bad = 1'b1;
            if (drv < 3) begin
                bus16.opcode = OP_ADD; bus16.zx = 1'b0; bus16.sw = 1'b0;
                bus16.use_acc = ua_v[drv]; bus16.acc_clr = clr_v[drv];
                bus16.reg1 = r1_v[drv]; bus16.reg2 = r2_v[drv];
                bus16.in_valid = 1'b1;
                #1;
                if (!bus16.in_ready) gap = 1'b1;
                drv++;
            end else begin
                bus16.in_valid = 1'b0;
            end
        end
        bus16.in_valid = 1'b0;
        checks++; if (gap !== 1'b0) begin errors++; $display("FAIL b2b_in_ready: got stall expected none"); end
        checks++; if (acc_bad !== 1'b0) begin errors++; $display("FAIL b2b_acc_clear: got nonzero expected 0000"); end
        checks++; if (got.size() !== 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", got.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_r[i]) begin
                errors++;
                $display("FAIL b2b_result%0d: got %h expected %h", i, (i < got.size()) ? got[i] : 16'hxxxx, exp_r[i]);
            end
        end
        checks++; if (bus16.acc !== 16'h0008) begin errors++; $display("FAIL b2b_acc_final: got %h expected 0008", bus16.acc); end
    endtask

    task automatic test_backpressure();
        logic [15:0] got[$];
        int drv = 0;
        int acc_stall = 0;
        int stall_bad = 0;
        int dup = 0;
        logic rdy_c4 = 1'bx;
        for (int c = 0; c < 30 && got.size() < 4; c++) begin
            @(negedge clk);
            bus16.out_ready = (c >= 5);
            if (bus16.out_valid && bus16.out_ready) got.push_back(bus16.result);
            if (c >= 2 && c < 5) begin
                if (bus16.out_valid !== 1'b1 || bus16.result !== 16'h0011 || bus16.flags !== 4'b0000)
                    stall_bad++;
            end
            if (drv < 4) begin
                bus16.opcode = OP_ADD; bus16.zx = 1'b0; bus16.sw = 1'b0;
                bus16.use_acc = 1'b0; bus16.acc_clr = 1'b0;
                bus16.reg1 = 16'(drv + 1); bus16.reg2 = 16'h0010;
                bus16.in_valid = 1'b1;
                #1;
                if (c == 4) rdy_c4 = bus16.in_ready;
                if (bus16.in_ready) begin
                    if (c < 5) acc_stall++;
                    drv++;
                end
            end else begin
                bus16.in_valid = 1'b0;
            end
        end
        bus16.in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus16.out_valid) dup++;
        end
        checks++; if (acc_stall !== 2) begin errors++; $display("FAIL bp_accepted_while_stalled: got %0d expected 2", acc_stall); end
        checks++; if (rdy_c4 !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", rdy_c4); end
        checks++; if (stall_bad !== 0) begin errors++; $display("FAIL bp_hold_stable: got %0d unstable cycles expected 0", stall_bad); end
        checks++; if (got.size() !== 4) begin errors++; $display("FAIL bp_count: got %0d expected 4", got.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== 16'(16'h0011 + i)) begin
                errors++;
                $display("FAIL bp_result%0d: got %h expected %h", i, (i < got.size()) ? got[i] : 16'hxxxx, 16'(16'h0011 + i));
            end
        end
        checks++; if (dup !== 0) begin errors++; $display("FAIL bp_duplicate: got %0d extra results expected 0", dup); end
    endtask

    task automatic test_reset_inflight();
        int stale = 0;
        logic [15:0] acc_before;
        bus16.out_ready = 1'b1;
        @(negedge clk);
        bus16.opcode = OP_ADD; bus16.zx = 1'b0; bus16.sw = 1'b0;
        bus16.use_acc = 1'b0; bus16.acc_clr = 1'b0;
        bus16.reg1 = 16'h0001; bus16.reg2 = 16'h0002; bus16.in_valid = 1'b1;
        @(negedge clk);
        bus16.reg1 = 16'h0004; bus16.reg2 = 16'h0004;
        @(negedge clk);
        acc_before = bus16.acc;
        bus16.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (acc_before !== 16'h0003) begin errors++; $display("FAIL rsti_acc_before: got %h expected 0003", acc_before); end
        checks++; if (bus16.out_valid !== 1'b0) begin errors++; $display("FAIL rsti_out_valid: got %b expected 0", bus16.out_valid); end
        checks++; if (bus16.in_ready !== 1'b1) begin errors++; $display("FAIL rsti_in_ready: got %b expected 1", bus16.in_ready); end
        checks++; if (bus16.acc !== 16'h0000) begin errors++; $display("FAIL rsti_acc: got %h expected 0000", bus16.acc); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus16.out_valid) stale++;
        end
        checks++; if (stale !== 0) begin errors++; $display("FAIL rsti_stale: got %0d results expected 0", stale); end
    endtask

    task automatic test_width8();
        logic [7:0] res; logic [3:0] flg; int lat;
        send8(OP_ADD, 8'hFF, 8'h01, res, flg, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL w8_latency: got %0d expected 2", lat); end
        checks++; if (res !== 8'h00 || flg !== 4'b1010) begin errors++; $display("FAIL w8_add: got %h/%b expected 00/1010", res, flg); end
        send8(OP_SUB, 8'h80, 8'h01, res, flg, lat);
        checks++; if (res !== 8'h7F || flg !== 4'b0001) begin errors++; $display("FAIL w8_sub_ovf: got %h/%b expected 7f/0001", res, flg); end
        send8(OP_SUB, 8'h03, 8'h05, res, flg, lat);
        checks++; if (res !== 8'hFE || flg !== 4'b0110) begin errors++; $display("FAIL w8_sub_borrow: got %h/%b expected fe/0110", res, flg); end
        send8(OP_OR, 8'h0F, 8'h80, res, flg, lat);
        checks++; if (res !== 8'h8F || flg !== 4'b0100) begin errors++; $display("FAIL w8_or: got %h/%b expected 8f/0100", res, flg); end
        checks++; if (bus8.acc !== 8'h8F) begin errors++; $display("FAIL w8_acc: got %h expected 8f", bus8.acc); end
    endtask

    initial begin
        bus16.in_valid = 1'b0; bus16.out_ready = 1'b0;
        bus16.opcode = OP_AND; bus16.zx = 1'b0; bus16.sw = 1'b0;
        bus16.use_acc = 1'b0; bus16.acc_clr = 1'b0;
        bus16.reg1 = '0; bus16.reg2 = '0;
        bus8.in_valid = 1'b0; bus8.out_ready = 1'b0;
        bus8.opcode = OP_AND; bus8.zx = 1'b0; bus8.sw = 1'b0;
        bus8.use_acc = 1'b0; bus8.acc_clr = 1'b0;
        bus8.reg1 = '0; bus8.reg2 = '0;

        test_reset();
        test_add();
        test_sub();
        test_zx_sw();
        test_back_to_back();
        test_backpressure();
        test_reset_inflight();
        test_width8();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
